// File: rtl/miner_pkg.sv
// Shared constants for the miner output path: frame layout and framer state codes.
package miner_pkg;

  localparam logic [7:0] FRAME_HDR = 8'hA5;
  localparam int         FRAME_LEN = 6;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] LOAD = 3'd1;
  localparam logic [2:0] HDR  = 3'd2;
  localparam logic [2:0] B3   = 3'd3;
  localparam logic [2:0] B2   = 3'd4;
  localparam logic [2:0] B1   = 3'd5;
  localparam logic [2:0] B0   = 3'd6;
  localparam logic [2:0] CSUM = 3'd7;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with power-of-two depth. The caller must not push when full
// (unless popping in the same cycle) nor pop when empty.
module sync_fifo #(
  parameter int WIDTH      = 32,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [WIDTH-1:0]      din,
  output logic [WIDTH-1:0]      dout,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH_LOG2:0]   count
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers are exactly DEPTH_LOG2 bits so they wrap on their own.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign dout  = mem[rd_ptr];
  assign full  = count[DEPTH_LOG2];
  assign empty = (count == '0);

endmodule

// File: rtl/golden_nonce_framer.sv
// Buffers golden nonces and serialises each into a 6-byte frame
// (header, nonce MSB first, XOR checksum) over a byte valid/ready handshake.
module golden_nonce_framer
  import miner_pkg::*;
#(
  parameter int         FIFO_LOG2 = 2,
  parameter logic [7:0] HDR_BYTE  = FRAME_HDR
) (
  input  logic                 hash_clk,
  input  logic                 reset,
  input  logic                 new_golden_nonce,
  input  logic [31:0]          golden_nonce,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [FIFO_LOG2:0]   fifo_count,
  output logic                 overflow,
  output logic [7:0]           drop_count
);

  logic [2:0]  state;
  logic [31:0] nonce_q;
  logic [31:0] head;
  logic [7:0]  csum;
  logic        full;
  logic        empty;
  logic        pop;
  logic        push;
  logic        drop;
  logic        xfer;

  // A full FIFO still accepts a nonce when the FSM pops in the same cycle.
  assign pop  = (state == IDLE) && !empty;
  assign push = new_golden_nonce && (!full || pop);
  assign drop = new_golden_nonce && !push;
  assign xfer = tx_valid && tx_ready;

  sync_fifo #(
    .WIDTH      (32),
    .DEPTH_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (hash_clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (golden_nonce),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      state    <= IDLE;
      nonce_q  <= '0;
      csum     <= '0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!empty) begin
            nonce_q <= head;
            state   <= LOAD;
          end
        end
        LOAD: begin
          tx_data  <= HDR_BYTE;
          tx_valid <= 1'b1;
          csum     <= 8'h00;
          state    <= HDR;
        end
        HDR: begin
          if (xfer) begin
            tx_data <= nonce_q[31:24];
            state   <= B3;
          end
        end
        B3: begin
          if (xfer) begin
            csum    <= csum ^ tx_data;
            tx_data <= nonce_q[23:16];
            state   <= B2;
          end
        end
        B2: begin
          if (xfer) begin
            csum    <= csum ^ tx_data;
            tx_data <= nonce_q[15:8];
            state   <= B1;
          end
        end
        B1: begin
          if (xfer) begin
            csum    <= csum ^ tx_data;
            tx_data <= nonce_q[7:0];
            state   <= B0;
          end
        end
        // The checksum byte folds in the last nonce byte as it leaves.
        B0: begin
          if (xfer) begin
            csum    <= csum ^ tx_data;
            tx_data <= csum ^ tx_data;
            state   <= CSUM;
          end
        end
        CSUM: begin
          if (xfer) begin
            tx_data  <= 8'h00;
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge hash_clk) begin
    if (reset) begin
      overflow   <= 1'b0;
      drop_count <= 8'h00;
    end else if (drop) begin
      overflow <= 1'b1;
      if (drop_count != 8'hFF) drop_count <= drop_count + 8'h01;
    end
  end

endmodule

// File: tb/tb_golden_nonce_framer.sv
// Directed bench for golden_nonce_framer: latency, backpressure, burst/overflow,
// full-with-pop, mid-frame reset and drop-counter saturation.
module tb_golden_nonce_framer;
  import miner_pkg::*;

  logic        hash_clk;
  logic        reset;
  logic        new_golden_nonce;
  logic [31:0] golden_nonce;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [2:0]  fifo_count;
  logic        overflow;
  logic [7:0]  drop_count;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q [$];

  golden_nonce_framer #(
    .FIFO_LOG2 (2),
    .HDR_BYTE  (8'hA5)
  ) dut (
    .hash_clk         (hash_clk),
    .reset            (reset),
    .new_golden_nonce (new_golden_nonce),
    .golden_nonce     (golden_nonce),
    .tx_data          (tx_data),
    .tx_valid         (tx_valid),
    .tx_ready         (tx_ready),
    .fifo_count       (fifo_count),
    .overflow         (overflow),
    .drop_count       (drop_count)
  );

  initial hash_clk = 1'b0;
  always #5 hash_clk = ~hash_clk;

  // Every accepted byte is captured at the edge where the handshake completes.
  always @(posedge hash_clk) begin
    if (!reset && tx_valid && tx_ready) rx_q.push_back(tx_data);
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One-cycle strobe, driven from a negedge and sampled by the next posedge.
  task automatic applyStimulus(input logic [31:0] n);
    new_golden_nonce = 1'b1;
    golden_nonce     = n;
    @(negedge hash_clk);
    new_golden_nonce = 1'b0;
  endtask

  task automatic waitBytes(input string tag, input int n, input int budget);
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge hash_clk);
    checkOutput({tag, "_count"}, rx_q.size(), n);
  endtask

  task automatic checkFrame(input string tag, input logic [31:0] n, input logic [7:0] cs);
    logic [7:0] exp [FRAME_LEN];
    logic [7:0] got;
    exp[0] = 8'hA5;
    exp[1] = n[31:24];
    exp[2] = n[23:16];
    exp[3] = n[15:8];
    exp[4] = n[7:0];
    exp[5] = cs;
    if (rx_q.size() < FRAME_LEN) begin
      checkOutput({tag, "_avail"}, rx_q.size(), FRAME_LEN);
    end else begin
      for (int i = 0; i < FRAME_LEN; i++) begin
        got = rx_q.pop_front();
        checkOutput($sformatf("%s_b%0d", tag, i), got, exp[i]);
      end
    end
  endtask

  task automatic doReset();
    reset = 1'b1;
    @(negedge hash_clk);
    @(negedge hash_clk);
    reset = 1'b0;
    rx_q.delete();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    new_golden_nonce = 1'b0;
    golden_nonce     = 32'h0;
    tx_ready         = 1'b0;
    @(negedge hash_clk);
    @(negedge hash_clk);
    reset = 1'b0;

    checkOutput("rst_valid", tx_valid, 1'b0);
    checkOutput("rst_data", tx_data, 8'h00);
    checkOutput("rst_count", fifo_count, 3'd0);
    checkOutput("rst_ovf", overflow, 1'b0);
    checkOutput("rst_drops", drop_count, 8'h00);

    // Single nonce; checksum DE^AD^BE^EF = 22.
    tx_ready = 1'b1;
    applyStimulus(32'hDEADBEEF);
    checkOutput("lat_n0_valid", tx_valid, 1'b0);
    @(negedge hash_clk);
    checkOutput("lat_n1_valid", tx_valid, 1'b0);
    @(negedge hash_clk);
    checkOutput("lat_n2_valid", tx_valid, 1'b1);
    checkOutput("lat_n2_data", tx_data, 8'hA5);
    waitBytes("single", 6, 20);
    checkFrame("single", 32'hDEADBEEF, 8'h22);
    repeat (3) @(negedge hash_clk);
    checkOutput("single_count_end", fifo_count, 3'd0);
    checkOutput("single_idle", tx_valid, 1'b0);
    checkOutput("single_extra", rx_q.size(), 0);

    // Backpressure 1-0-0-1; checksum 01^02^03^04 = 04.
    applyStimulus(32'h01020304);
    @(negedge hash_clk);
    @(negedge hash_clk);
    checkOutput("bp_hdr_valid", tx_valid, 1'b1);
    @(negedge hash_clk);
    tx_ready = 1'b0;
    checkOutput("bp_b3", tx_data, 8'h01);
    @(negedge hash_clk);
    checkOutput("bp_stall1_data", tx_data, 8'h01);
    checkOutput("bp_stall1_valid", tx_valid, 1'b1);
    @(negedge hash_clk);
    checkOutput("bp_stall2_data", tx_data, 8'h01);
    checkOutput("bp_stall2_valid", tx_valid, 1'b1);
    tx_ready = 1'b1;
    waitBytes("bp", 6, 20);
    checkFrame("bp", 32'h01020304, 8'h04);

    // Burst of six with the transmitter stalled: 1 in flight, 4 buffered, 1 lost.
    doReset();
    tx_ready = 1'b0;
    new_golden_nonce = 1'b1;
    golden_nonce = 32'h10000000; @(negedge hash_clk);
    golden_nonce = 32'h20000001; @(negedge hash_clk);
    golden_nonce = 32'h30000002; @(negedge hash_clk);
    golden_nonce = 32'h40000003; @(negedge hash_clk);
    golden_nonce = 32'h50000004; @(negedge hash_clk);
    golden_nonce = 32'h60000005; @(negedge hash_clk);
    new_golden_nonce = 1'b0;
    checkOutput("burst_count", fifo_count, 3'd4);
    checkOutput("burst_ovf", overflow, 1'b1);
    checkOutput("burst_drops", drop_count, 8'h01);
    checkOutput("burst_valid", tx_valid, 1'b1);
    checkOutput("burst_hdr", tx_data, 8'hA5);

    // Release and land a strobe on the IDLE cycle where the full FIFO pops.
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && tx_valid; i++) @(negedge hash_clk);
    checkOutput("fullpop_gap", tx_valid, 1'b0);
    checkOutput("fullpop_pre_count", fifo_count, 3'd4);
    applyStimulus(32'h70000006);
    checkOutput("fullpop_count", fifo_count, 3'd4);
    checkOutput("fullpop_drops", drop_count, 8'h01);
    waitBytes("burst", 36, 80);
    checkFrame("burst1", 32'h10000000, 8'h10);
    checkFrame("burst2", 32'h20000001, 8'h21);
    checkFrame("burst3", 32'h30000002, 8'h32);
    checkFrame("burst4", 32'h40000003, 8'h43);
    checkFrame("burst5", 32'h50000004, 8'h54);
    checkFrame("burst6", 32'h70000006, 8'h76);

    // Saturation: 5 strobes are absorbed, the remaining 300 are dropped.
    doReset();
    tx_ready = 1'b0;
    new_golden_nonce = 1'b1;
    for (int i = 0; i < 259; i++) begin
      golden_nonce = 32'(i);
      @(negedge hash_clk);
    end
    checkOutput("sat_fe", drop_count, 8'hFE);
    for (int i = 0; i < 46; i++) begin
      golden_nonce = 32'(i + 1000);
      @(negedge hash_clk);
    end
    new_golden_nonce = 1'b0;
    checkOutput("sat_ff", drop_count, 8'hFF);
    checkOutput("sat_ovf", overflow, 1'b1);

    // Reset once A5, B3 and B2 have been sent.
    tx_ready = 1'b1;
    for (int i = 0; i < 20 && rx_q.size() < 3; i++) @(negedge hash_clk);
    checkOutput("midrst_pre_bytes", rx_q.size(), 3);
    reset = 1'b1;
    @(negedge hash_clk);
    checkOutput("midrst_valid", tx_valid, 1'b0);
    checkOutput("midrst_data", tx_data, 8'h00);
    checkOutput("midrst_count", fifo_count, 3'd0);
    checkOutput("midrst_ovf", overflow, 1'b0);
    checkOutput("midrst_drops", drop_count, 8'h00);
    reset = 1'b0;
    rx_q.delete();
    repeat (3) @(negedge hash_clk);
    checkOutput("midrst_quiet", rx_q.size(), 0);
    // CA^FE^F0^0D = C9.
    applyStimulus(32'hCAFEF00D);
    waitBytes("post_rst", 6, 20);
    checkFrame("post_rst", 32'hCAFEF00D, 8'hC9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
